noc_local_injector: RTL and testbench
=====================================

// Module: noc_local_injector
// PURPOSE
//  Network-interface transmitter for a router's local port: accepts packet requests from the core,
//  queues them in a small FIFO, formats them as single-flit packets and injects them into the router
//  input, honouring the router's per-port availability signal. Sits between the core and router input 4.
// PARAMETERS
//  CS          2   coordinate width per axis (X and Y)
//  DATA_W      3   payload width
//  PL          1+2*CS+DATA_W (8)  flit width; must match router PL
//  FIFO_DEPTH  4   request queue entries (power of 2, >=2)
//  MAX_WAIT    15  consecutive stalled cycles before stall_timeout pulses
// PORTS
//  clk            in   1         clock, all state on posedge
//  rst_n          in   1         async active-low reset
//  req_valid      in   1         core offers a packet
//  req_ready      out  1         queue can accept (= !full)
//  req_dest_x     in   CS        destination X
//  req_dest_y     in   CS        destination Y
//  req_data       in   DATA_W    payload
//  router_X       in   CS        own router X (static)
//  router_Y       in   CS        own router Y (static)
//  avail_in       in   1         router availability for this input port (1 = accepts flit)
//  flit_out       out  [0:PL-1]  flit to router input; bit 0 = valid
//  fifo_count     out  log2(FIFO_DEPTH)+1  current occupancy
//  self_drop      out  1         1-cycle pulse: request addressed to self discarded
//  stall_timeout  out  1         1-cycle pulse: MAX_WAIT consecutive stalled cycles reached
//  sent_count     out  16        flits injected, wraps at 2^16
// BEHAVIOUR
//  Reset (rst_n=0, async): FIFO emptied, flit_out=0, fifo_count=0, pulses=0, sent_count=0, state=IDLE.
//  Flit format: flit[0]=1, flit[1:CS]=dest_x, flit[CS+1:2*CS]=dest_y, flit[2*CS+1:PL-1]=data (MSB first).
//  Push: at posedge with req_valid & req_ready; dest==(router_X,router_Y) -> not queued, self_drop=1 next cycle.
//  req_ready = (fifo_count < FIFO_DEPTH), combinational from count; push while full impossible.
//  Pop: at posedge with FIFO non-empty & avail_in=1 -> flit_out <= formatted head; else flit_out <= 0.
//  flit_out is registered, held exactly one cycle per flit; no flit repeats; max 1 flit/cycle.
//  Latency: request accepted at edge N appears on flit_out after edge N+1 if FIFO was empty and avail_in=1.
//  Simultaneous push+pop: both occur, count unchanged; push into empty FIFO is not popped same edge.
//  Order strictly FIFO; pointers wrap modulo FIFO_DEPTH.
//  FSM: IDLE (empty) -> SEND on non-empty & avail_in; -> STALL on non-empty & !avail_in.
//   SEND: pop each cycle while avail_in; -> STALL if !avail_in & non-empty; -> IDLE when empty.
//   STALL: wait_cnt increments per cycle with avail_in=0; when wait_cnt reaches MAX_WAIT,
//   stall_timeout pulses once, wait_cnt saturates (no re-pulse) until avail_in=1; -> SEND on avail_in.
//   wait_cnt clears on leaving STALL. Packets never dropped on timeout.
//  sent_count += 1 on every pop; wraps 16'hFFFF -> 0.
//  Reset mid-operation: queued and in-flight flits discarded, flit_out forced 0 immediately.
// TESTING
//  1) router (1,1), avail=1, push dest(2,3) data 5 -> next-but-one cycle flit_out=8'hDD for 1 cycle, then 8'h00.
//  2) push 4 back-to-back (avail=0): (0,2,1),(2,3,5),(3,0,2),(0,1,7) -> req_ready=0, count=4;
//     raise avail -> flit_out 8'h91,8'hDD,8'hE2,8'h8F on consecutive cycles, sent_count=4.
//  3) push dest(1,1) with router (1,1) -> self_drop pulse, fifo_count stays 0, flit_out stays 0.
//  4) 1 entry queued, avail=0 for 20 cycles -> stall_timeout single pulse after 15th stalled cycle;
//     avail=1 -> flit delivered unchanged.
//  5) count=2, avail=1, push every cycle -> count stays 2, order preserved, no gap cycles on flit_out.
//  6) rst_n low mid-burst with 3 queued -> flit_out=0 at once, count=0; after release, no stale flit emitted.

Source files
------------

// File: rtl/noc_local_injector.sv
// rtl/noc_local_injector.sv - local-port transmitter: queues core packet requests and injects single-flit packets into the router
module noc_local_injector #(
    parameter int CS         = 2,
    parameter int DATA_W     = 3,
    parameter int PL         = 1 + 2 * CS + DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [CS-1:0]                 req_dest_x,
    input  logic [CS-1:0]                 req_dest_y,
    input  logic [DATA_W-1:0]             req_data,
    input  logic [CS-1:0]                 router_X,
    input  logic [CS-1:0]                 router_Y,
    input  logic                          avail_in,
    output logic [0:PL-1]                 flit_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          self_drop,
    output logic                          stall_timeout,
    output logic [15:0]                   sent_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STALL = 2'd2
    } state_t;

    // Entry holds the flit body without the valid bit: {dest_x, dest_y, data}
    logic [PL-2:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [0:PL-1]       flit_q, flit_d;
    logic                self_drop_q, self_drop_d;
    logic                timeout_q, timeout_d;
    logic [15:0]         sent_q, sent_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    state_t              state_q, state_d;

    logic empty;
    logic is_self;
    logic accept;
    logic push;
    logic pop;

    assign empty     = (count_q == '0);
    assign req_ready = (count_q < DEPTH_C);
    assign is_self   = (req_dest_x == router_X) && (req_dest_y == router_Y);
    assign accept    = req_valid && req_ready;
    assign push      = accept && !is_self;
    // Pop looks at pre-edge occupancy, so an entry pushed into an empty queue waits one edge
    assign pop       = !empty && avail_in;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        flit_d      = '0;
        self_drop_d = accept && is_self;
        sent_d      = sent_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            flit_d   = {1'b1, mem_q[rd_ptr_q]};
            sent_d   = sent_q + 16'd1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    if (avail_in) begin
                        state_d = SEND;
                    end else begin
                        state_d   = STALL;
                        wait_d    = WAIT_ONE;
                        timeout_d = (MAX_WAIT_C == WAIT_ONE);
                    end
                end
            end
            SEND: begin
                if (empty) begin
                    state_d = IDLE;
                end else if (!avail_in) begin
                    state_d   = STALL;
                    wait_d    = WAIT_ONE;
                    timeout_d = (MAX_WAIT_C == WAIT_ONE);
                end
            end
            STALL: begin
                if (avail_in) begin
                    state_d = SEND;
                end else begin
                    // Saturate at MAX_WAIT so the timeout pulses once per stall episode
                    wait_d    = (wait_q == MAX_WAIT_C) ? wait_q : wait_q + WAIT_ONE;
                    timeout_d = (wait_q == MAX_WAIT_C - WAIT_ONE);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {req_dest_x, req_dest_y, req_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            flit_q      <= '0;
            self_drop_q <= 1'b0;
            timeout_q   <= 1'b0;
            sent_q      <= '0;
            wait_q      <= '0;
            state_q     <= IDLE;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            flit_q      <= flit_d;
            self_drop_q <= self_drop_d;
            timeout_q   <= timeout_d;
            sent_q      <= sent_d;
            wait_q      <= wait_d;
            state_q     <= state_d;
        end
    end

    assign flit_out      = flit_q;
    assign fifo_count    = count_q;
    assign self_drop     = self_drop_q;
    assign stall_timeout = timeout_q;
    assign sent_count    = sent_q;

endmodule

// File: tb/tb_noc_local_injector.sv
// tb/tb_noc_local_injector.sv - self-checking bench for noc_local_injector
module tb_noc_local_injector;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_dest_x;
    logic [1:0]  req_dest_y;
    logic [2:0]  req_data;
    logic [1:0]  router_X;
    logic [1:0]  router_Y;
    logic        avail_in;
    logic [0:7]  flit_out;
    logic [2:0]  fifo_count;
    logic        self_drop;
    logic        stall_timeout;
    logic [15:0] sent_count;

    noc_local_injector dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dest_x    (req_dest_x),
        .req_dest_y    (req_dest_y),
        .req_data      (req_data),
        .router_X      (router_X),
        .router_Y      (router_Y),
        .avail_in      (avail_in),
        .flit_out      (flit_out),
        .fifo_count    (fifo_count),
        .self_drop     (self_drop),
        .stall_timeout (stall_timeout),
        .sent_count    (sent_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a queue of formatted flits plus the observable registered outputs
    logic [7:0]  m_q[$];
    logic [7:0]  m_flit;
    logic        m_drop;
    logic        m_tmo;
    logic [15:0] m_sent;
    int          m_run;

    typedef struct packed {
        logic        valid;
        logic [1:0]  dx;
        logic [1:0]  dy;
        logic [2:0]  data;
        logic        avail;
        logic [7:0]  e_flit;
        logic [2:0]  e_count;
        logic        e_ready;
        logic        e_drop;
        logic [15:0] e_sent;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_flit = 8'h00;
        m_drop = 1'b0;
        m_tmo  = 1'b0;
        m_sent = 16'd0;
        m_run  = 0;
    endtask

    // Advance model and DUT one edge with the currently driven inputs, then compare
    task automatic cycle();
        bit ready;
        bit stalled;
        ready   = (m_q.size() < 4);
        stalled = (m_q.size() > 0) && !avail_in;
        if (m_q.size() > 0 && avail_in) begin
            m_flit = m_q.pop_front();
            m_sent = m_sent + 16'd1;
        end else begin
            m_flit = 8'h00;
        end
        m_drop = 1'b0;
        if (req_valid && ready) begin
            if (req_dest_x == router_X && req_dest_y == router_Y)
                m_drop = 1'b1;
            else
                m_q.push_back({1'b1, req_dest_x, req_dest_y, req_data});
        end
        m_run = stalled ? m_run + 1 : 0;
        m_tmo = stalled && (m_run == MAX_WAIT);
        @(posedge clk);
        #1;
        chk("flit_out", 32'(flit_out), 32'(m_flit));
        chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
        chk("req_ready", 32'(req_ready), 32'(m_q.size() < 4));
        chk("self_drop", 32'(self_drop), 32'(m_drop));
        chk("stall_timeout", 32'(stall_timeout), 32'(m_tmo));
        chk("sent_count", 32'(sent_count), 32'(m_sent));
    endtask

    task automatic drive(input logic v, input logic [1:0] x, input logic [1:0] y,
                         input logic [2:0] d, input logic a);
        req_valid  = v;
        req_dest_x = x;
        req_dest_y = y;
        req_data   = d;
        avail_in   = a;
    endtask

    initial begin
        int npulse;
        int pulse_at;

        rst_n    = 1'b0;
        router_X = 2'd1;
        router_Y = 2'd1;
        drive(1'b0, 2'd0, 2'd0, 3'd0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst flit_out", 32'(flit_out), 32'h0);
        chk("rst fifo_count", 32'(fifo_count), 32'h0);
        chk("rst req_ready", 32'(req_ready), 32'h1);
        chk("rst sent_count", 32'(sent_count), 32'h0);
        chk("rst pulses", 32'({self_drop, stall_timeout}), 32'h0);
        rst_n = 1'b1;

        // Directed vectors: single flit, burst of four while stalled, self-addressed drop
        tbl[0]  = '{1'b1, 2'd2, 2'd3, 3'd5, 1'b1, 8'h00, 3'd1, 1'b1, 1'b0, 16'd0};
        tbl[1]  = '{1'b0, 2'd0, 2'd0, 3'd0, 1'b1, 8'hDD, 3'd0, 1'b1, 1'b0, 16'd1};
        tbl[2]  = '{1'b0, 2'd0, 2'd0, 3'd0, 1'b1, 8'h00, 3'd0, 1'b1, 1'b0, 16'd1};
        tbl[3]  = '{1'b1, 2'd0, 2'd2, 3'd1, 1'b0, 8'h00, 3'd1, 1'b1, 1'b0, 16'd1};
        tbl[4]  = '{1'b1, 2'd2, 2'd3, 3'd5, 1'b0, 8'h00, 3'd2, 1'b1, 1'b0, 16'd1};
        tbl[5]  = '{1'b1, 2'd3, 2'd0, 3'd2, 1'b0, 8'h00, 3'd3, 1'b1, 1'b0, 16'd1};
        tbl[6]  = '{1'b1, 2'd0, 2'd1, 3'd7, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0, 16'd1};
        tbl[7]  = '{1'b0, 2'd0, 2'd0, 3'd0, 1'b1, 8'h91, 3'd3, 1'b1, 1'b0, 16'd2};
        tbl[8]  = '{1'b0, 2'd0, 2'd0, 3'd0, 1'b1, 8'hDD, 3'd2, 1'b1, 1'b0, 16'd3};
        tbl[9]  = '{1'b0, 2'd0, 2'd0, 3'd0, 1'b1, 8'hE2, 3'd1, 1'b1, 1'b0, 16'd4};
        tbl[10] = '{1'b0, 2'd0, 2'd0, 3'd0, 1'b1, 8'h8F, 3'd0, 1'b1, 1'b0, 16'd5};
        tbl[11] = '{1'b0, 2'd0, 2'd0, 3'd0, 1'b1, 8'h00, 3'd0, 1'b1, 1'b0, 16'd5};
        tbl[12] = '{1'b1, 2'd1, 2'd1, 3'd3, 1'b1, 8'h00, 3'd0, 1'b1, 1'b1, 16'd5};
        tbl[13] = '{1'b0, 2'd0, 2'd0, 3'd0, 1'b1, 8'h00, 3'd0, 1'b1, 1'b0, 16'd5};

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].valid, tbl[i].dx, tbl[i].dy, tbl[i].data, tbl[i].avail);
            cycle();
            chk($sformatf("vec%0d flit", i), 32'(flit_out), 32'(tbl[i].e_flit));
            chk($sformatf("vec%0d count", i), 32'(fifo_count), 32'(tbl[i].e_count));
            chk($sformatf("vec%0d ready", i), 32'(req_ready), 32'(tbl[i].e_ready));
            chk($sformatf("vec%0d drop", i), 32'(self_drop), 32'(tbl[i].e_drop));
            chk($sformatf("vec%0d sent", i), 32'(sent_count), 32'(tbl[i].e_sent));
        end

        // Stall timeout: one entry held back for 20 cycles
        drive(1'b1, 2'd3, 2'd2, 3'd6, 1'b0);
        cycle();
        npulse   = 0;
        pulse_at = -1;
        for (int k = 1; k <= 20; k++) begin
            drive(1'b0, 2'd0, 2'd0, 3'd0, 1'b0);
            cycle();
            if (stall_timeout) begin
                npulse++;
                pulse_at = k;
            end
        end
        chk("timeout pulses", 32'(npulse), 32'd1);
        chk("timeout position", 32'(pulse_at), 32'd15);
        drive(1'b0, 2'd0, 2'd0, 3'd0, 1'b1);
        cycle();
        chk("stalled flit", 32'(flit_out), 32'hF6);
        cycle();

        // Simultaneous push and pop with two entries queued
        drive(1'b1, 2'd0, 2'd3, 3'd1, 1'b0);
        cycle();
        drive(1'b1, 2'd2, 2'd0, 3'd4, 1'b0);
        cycle();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 2'(k), 2'(k + 2), 3'(k), 1'b1);
            if (k[1:0] == 2'd1 && (k + 2) % 4 == 1) req_dest_y = 2'd0;
            cycle();
            chk("pushpop count", 32'(fifo_count), 32'd2);
            chk("pushpop no gap", 32'(flit_out[0]), 32'd1);
        end
        drive(1'b0, 2'd0, 2'd0, 3'd0, 1'b1);
        repeat (3) cycle();

        // Asynchronous reset mid-burst with three queued and one flit in flight
        drive(1'b1, 2'd0, 2'd2, 3'd3, 1'b0);
        cycle();
        drive(1'b1, 2'd2, 2'd2, 3'd1, 1'b0);
        cycle();
        drive(1'b1, 2'd3, 2'd3, 3'd2, 1'b0);
        cycle();
        drive(1'b1, 2'd2, 2'd1, 3'd7, 1'b1);
        cycle();
        drive(1'b0, 2'd0, 2'd0, 3'd0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst flit_out", 32'(flit_out), 32'h0);
        chk("midrst fifo_count", 32'(fifo_count), 32'h0);
        chk("midrst sent_count", 32'(sent_count), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("postrst no stale", 32'(flit_out), 32'h0);
        end

        // Randomised traffic against the model, alternating busy and congested phases
        for (int k = 0; k < 600; k++) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            req_dest_x = 2'($urandom_range(0, 3));
            req_dest_y = 2'($urandom_range(0, 3));
            req_data   = 3'($urandom_range(0, 7));
            if ((k / 100) % 2 == 0)
                avail_in = ($urandom_range(0, 9) < 7);
            else
                avail_in = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
